// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle for the instruction memory.
// Master is the fetch stage; slave is the responder.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instruction;
    logic [63:0] resp_pc;
    logic        resp_fault;

    modport master (
        output req_valid,
        output req_pc,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_instruction,
        input  resp_pc,
        input  resp_fault
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_instruction,
        output resp_pc,
        output resp_fault
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency in-order reads with
// an output FIFO for backpressure, flush on redirect, and a load port.
module imem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 load_enable,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    imem_responder_if.slave      bus
);
    localparam int DEPTH = LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]          mem [2**ADDR_BITS];
    logic [CW-1:0]        outstanding;
    logic                 accept;
    logic                 deliver;
    logic [ADDR_BITS-1:0] idx;
    logic                 fault;
    logic [31:0]          rd_word;

    logic                 fin_valid;
    logic [63:0]          fin_pc;
    logic [31:0]          fin_data;
    logic                 fin_fault;

    logic [31:0]          f_data  [DEPTH];
    logic [63:0]          f_pc    [DEPTH];
    logic                 f_fault [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;

    assign bus.req_ready = reset_n && !flush
                        && (outstanding < CW'(DEPTH));
    assign accept  = bus.req_valid && bus.req_ready;
    assign deliver = bus.resp_valid && bus.resp_ready;
    assign idx     = bus.req_pc[ADDR_BITS+1:2];
    assign fault   = (|bus.req_pc[1:0])
                  || (|bus.req_pc[63:ADDR_BITS+2]);
    assign rd_word = fault ? NOP : mem[idx];

    // Array is never reset; NBA write keeps same-edge reads read-first.
    always_ff @(posedge clock) begin
        if (load_enable) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (flush) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(deliver);
        end
    end

    if (LATENCY == 1) begin : gen_direct
        assign fin_valid = accept;
        assign fin_pc    = bus.req_pc;
        assign fin_data  = rd_word;
        assign fin_fault = fault;
    end else begin : gen_pipe
        localparam int NS = LATENCY - 1;

        logic        pv  [NS];
        logic [63:0] ppc [NS];
        logic [31:0] pd  [NS];
        logic        pf  [NS];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < NS; i++) begin
                    pv[i]  <= 1'b0;
                    ppc[i] <= '0;
                    pd[i]  <= '0;
                    pf[i]  <= 1'b0;
                end
            end else begin
                pv[0]  <= accept;
                ppc[0] <= bus.req_pc;
                pd[0]  <= rd_word;
                pf[0]  <= fault;
                for (int i = 1; i < NS; i++) begin
                    pv[i]  <= pv[i-1];
                    ppc[i] <= ppc[i-1];
                    pd[i]  <= pd[i-1];
                    pf[i]  <= pf[i-1];
                end
                if (flush) begin
                    for (int i = 0; i < NS; i++) begin
                        pv[i] <= 1'b0;
                    end
                end
            end
        end

        assign fin_valid = pv[NS-1];
        assign fin_pc    = ppc[NS-1];
        assign fin_data  = pd[NS-1];
        assign fin_fault = pf[NS-1];
    end

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // outstanding caps pipe+FIFO occupancy, so the FIFO cannot overflow.
    assign push = fin_valid && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                f_data[i]  <= '0;
                f_pc[i]    <= '0;
                f_fault[i] <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                f_data[wr_ptr]  <= fin_data;
                f_pc[wr_ptr]    <= fin_pc;
                f_fault[wr_ptr] <= fin_fault;
                wr_ptr          <= bump(wr_ptr);
            end
            if (deliver) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(push) - CW'(deliver);
        end
    end

    assign bus.resp_valid       = (count != '0);
    assign bus.resp_instruction = f_data[rd_ptr];
    assign bus.resp_pc          = f_pc[rd_ptr];
    assign bus.resp_fault       = f_fault[rd_ptr];
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: queue-based reference model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_imem_responder;
    localparam int AB    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          load_enable = 1'b0;
    logic [AB-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;

    imem_responder_if bus();

    imem_responder #(
        .ADDR_BITS(AB),
        .LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .load_enable(load_enable),
        .load_addr(load_addr),
        .load_data(load_data),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: every accepted request becomes a queue entry that
    // is visible LAT-1 edges after acceptance and leaves when handshaken.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        logic        fault;
        int          rdy;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mmem [2**AB];
    int          edge_n = 0;

    function automatic logic m_fault(input logic [63:0] pc);
        return ((pc % 64'd4) != 64'd0) || (pc >= 64'(4 << AB));
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            bit head_vis;
            bit m_ready;
            head_vis = (q.size() > 0) && (q[0].rdy <= edge_n);
            m_ready  = !flush && (q.size() < DEPTH);
            edge_n++;
            if (flush) begin
                q.delete();
            end else begin
                if (head_vis && bus.resp_ready) begin
                    void'(q.pop_front());
                end
                if (bus.req_valid && m_ready) begin
                    resp_t r;
                    r.pc    = bus.req_pc;
                    r.fault = m_fault(bus.req_pc);
                    r.data  = r.fault ? 32'h13 : mmem[AB'(bus.req_pc >> 2)];
                    r.rdy   = edge_n + LAT - 1;
                    q.push_back(r);
                end
            end
            if (load_enable) begin
                mmem[load_addr] = load_data;
            end
        end
    end

    always @(negedge clock) begin
        bit er;
        bit ev;
        er = reset_n && !flush && (q.size() < DEPTH);
        ev = (q.size() > 0) && (q[0].rdy <= edge_n);
        chk("cyc_req_ready", 64'(bus.req_ready), 64'(er));
        chk("cyc_resp_valid", 64'(bus.resp_valid), 64'(ev));
        if (ev && bus.resp_valid) begin
            chk("cyc_instr", 64'(bus.resp_instruction), 64'(q[0].data));
            chk("cyc_pc", bus.resp_pc, q[0].pc);
            chk("cyc_fault", 64'(bus.resp_fault), 64'(q[0].fault));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_enable = 1'b1;
        load_addr   = AB'(a);
        load_data   = d;
        step();
        load_enable = 1'b0;
    endtask

    task automatic single(input logic [63:0] pc, input logic [31:0] ei,
                          input logic ef, input string tag);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_pc     = pc;
        step();
        bus.req_valid = 1'b0;
        repeat (LAT - 1) step();
        chk({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, "_instr"}, 64'(bus.resp_instruction), 64'(ei));
        chk({tag, "_pc"}, bus.resp_pc, pc);
        chk({tag, "_fault"}, 64'(bus.resp_fault), 64'(ef));
        step();
        step();
    endtask

    initial begin
        int n_acc;
        bus.req_valid  = 1'b0;
        bus.req_pc     = '0;
        bus.resp_ready = 1'b0;

        repeat (2) step();
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_instr", 64'(bus.resp_instruction), 64'd0);
        chk("rst_pc", bus.resp_pc, 64'd0);
        chk("rst_fault", 64'(bus.resp_fault), 64'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) load(i, 32'(i + 1));
        load(20, 32'd20);
        load(1023, 32'hdead_1023);

        // back-to-back reads
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_pc     = 64'd0;
        step();
        chk("b2b_first_lat", 64'(bus.resp_valid), 64'd0);
        bus.req_pc = 64'd4;
        step();
        chk("b2b_r0_instr", 64'(bus.resp_instruction), 64'd1);
        chk("b2b_r0_pc", bus.resp_pc, 64'd0);
        bus.req_pc = 64'd8;
        step();
        chk("b2b_r1_instr", 64'(bus.resp_instruction), 64'd2);
        chk("b2b_r1_pc", bus.resp_pc, 64'd4);
        bus.req_valid = 1'b0;
        step();
        chk("b2b_r2_instr", 64'(bus.resp_instruction), 64'd3);
        chk("b2b_r2_pc", bus.resp_pc, 64'd8);
        step();
        step();

        // backpressure
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        n_acc = 0;
        repeat (6) begin
            bus.req_pc = 64'(4 * n_acc);
            if (bus.req_ready) n_acc++;
            step();
        end
        chk("bp_accepts", 64'(n_acc), 64'd3);
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        chk("bp_head_held", 64'(bus.resp_instruction), 64'd1);
        bus.resp_ready = 1'b1;
        step();
        chk("bp_resume", 64'(bus.req_ready), 64'd1);
        chk("bp_second", 64'(bus.resp_instruction), 64'd2);
        step();
        bus.req_valid = 1'b0;
        repeat (5) step();

        // flush
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_pc     = 64'd0;
        step();
        bus.req_pc = 64'd4;
        step();
        flush       = 1'b1;
        bus.req_pc  = 64'd80;
        #1;
        chk("flush_ready", 64'(bus.req_ready), 64'd0);
        step();
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_clear", 64'(bus.resp_valid), 64'd0);
        repeat (3) step();
        chk("flush_no_stale", 64'(bus.resp_valid), 64'd0);
        single(64'd80, 32'd20, 1'b0, "post_flush");

        // faults and top word
        single(64'd6, 32'h13, 1'b1, "misaligned");
        single(64'd4096, 32'h13, 1'b1, "out_of_range");
        single(64'd4092, 32'hdead_1023, 1'b0, "top_word");

        // load/read collision is read-first
        load(5, 32'haa);
        load_enable    = 1'b1;
        load_addr      = AB'(5);
        load_data      = 32'hbb;
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_pc     = 64'd20;
        step();
        load_enable   = 1'b0;
        bus.req_valid = 1'b0;
        step();
        chk("rf_old_data", 64'(bus.resp_instruction), 64'haa);
        step();
        step();
        single(64'd20, 32'hbb, 1'b0, "rf_new_data");

        // asynchronous reset with reads outstanding
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_pc     = 64'd0;
        step();
        bus.req_pc = 64'd4;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("post_rst_empty", 64'(bus.resp_valid), 64'd0);
        single(64'd0, 32'd1, 1'b0, "post_rst_word0");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
